// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: op codes, FSM states,
// flag-vector layout and default settle time.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RESP
  } issuer_state_e;

  // rsp_flags layout: {zero, carry, sign, parity, overflow}
  localparam int unsigned FLAG_ZERO     = 4;
  localparam int unsigned FLAG_CARRY    = 3;
  localparam int unsigned FLAG_SIGN     = 2;
  localparam int unsigned FLAG_PARITY   = 1;
  localparam int unsigned FLAG_OVERFLOW = 0;
  localparam int unsigned FLAG_W        = 5;

  localparam int unsigned DEFAULT_SETTLE_CYCLES = 1;

  function automatic logic is_div_zero(input logic [1:0] op, input logic [3:0] b);
    return (op == OP_DIV) && (b == 4'd0);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and response handshake bundle between a requester and the issuer.
interface alu_cmd_issuer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_a;
  logic [3:0]        cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [3:0]        rsp_out;
  logic [FLAG_W-1:0] rsp_flags;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_sticky_status.sv
// Sticky carry/overflow/error accumulation and completed-transaction counter.
module alu_sticky_status (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture,
  input  logic       clr_sticky,
  input  logic       rsp_hs,
  input  logic       new_carry,
  input  logic       new_overflow,
  input  logic       new_err,
  output logic       sticky_carry,
  output logic       sticky_overflow,
  output logic       sticky_err,
  output logic [7:0] txn_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
      sticky_err      <= 1'b0;
      txn_count       <= '0;
    end else begin
      // A clear coinciding with a capture keeps only the newly captured bits
      if (capture) begin
        sticky_carry    <= (sticky_carry    & ~clr_sticky) | new_carry;
        sticky_overflow <= (sticky_overflow & ~clr_sticky) | new_overflow;
        sticky_err      <= (sticky_err      & ~clr_sticky) | new_err;
      end else if (clr_sticky) begin
        sticky_carry    <= 1'b0;
        sticky_overflow <= 1'b0;
        sticky_err      <= 1'b0;
      end
      if (rsp_hs) txn_count <= txn_count + 8'd1;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Accepts one ALU command at a time, holds it on the ALU for SETTLE_CYCLES,
// captures result and flags, and presents them until the consumer takes them.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.slave   bus,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [1:0]        alu_select,
  input  logic [3:0]        alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_sign,
  input  logic              alu_parity,
  input  logic              alu_overflow,
  input  logic              clr_sticky,
  output logic              sticky_carry,
  output logic              sticky_overflow,
  output logic              sticky_err,
  output logic [7:0]        txn_count
);

  issuer_state_e     state, state_nxt;
  logic [3:0]        settle_cnt;
  logic              accept, capture, rsp_hs, div_zero;
  logic [FLAG_W-1:0] alu_flags;

  always_comb begin
    alu_flags                = '0;
    alu_flags[FLAG_ZERO]     = alu_zero;
    alu_flags[FLAG_CARRY]    = alu_carry;
    alu_flags[FLAG_SIGN]     = alu_sign;
    alu_flags[FLAG_PARITY]   = alu_parity;
    alu_flags[FLAG_OVERFLOW] = alu_overflow;
  end

  assign div_zero = is_div_zero(alu_select, alu_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    capture       = 1'b0;
    rsp_hs        = 1'b0;
    bus.cmd_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
    case (state)
      S_IDLE: if (bus.cmd_valid) begin
        accept    = 1'b1;
        state_nxt = S_DRIVE;
      end
      S_DRIVE: if (settle_cnt == 4'd1) begin
        capture   = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) begin
        rsp_hs    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_select    <= '0;
      settle_cnt    <= '0;
      bus.rsp_out   <= '0;
      bus.rsp_flags <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a      <= bus.cmd_a;
        alu_b      <= bus.cmd_b;
        alu_select <= bus.cmd_op;
        settle_cnt <= 4'(SETTLE_CYCLES);
      end else if (state == S_DRIVE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture) begin
        bus.rsp_out   <= div_zero ? '0 : alu_out;
        bus.rsp_flags <= div_zero ? '0 : alu_flags;
        bus.rsp_err   <= div_zero;
      end
    end
  end

  alu_sticky_status u_sticky (
    .clk             (clk),
    .rst_n           (rst_n),
    .capture         (capture),
    .clr_sticky      (clr_sticky),
    .rsp_hs          (rsp_hs),
    .new_carry       (div_zero ? 1'b0 : alu_carry),
    .new_overflow    (div_zero ? 1'b0 : alu_overflow),
    .new_err         (div_zero),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow),
    .sticky_err      (sticky_err),
    .txn_count       (txn_count)
  );

endmodule
